comparator: RTL and testbench
=============================

Name: comparator

Overview:
- Registered magnitude comparator for two WIDTH-bit operands A and B.
- Produces one-hot less/equal/greater flags, one clock after a valid input sample.
- Used as a leaf datapath block wherever an ordered compare of two small fields is needed, e.g. arbitration, range checks and threshold detection.

Parameters:
- WIDTH, 2, operand width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A/B sample is valid this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  result flags refer to a newly accepted sample.
- A_less_B  output  1  registered flag, A < B.
- A_equal_B  output  1  registered flag, A == B.
- A_greater_B  output  1  registered flag, A > B.

Behaviour:
- One clock, synchronous active-high reset; no asynchronous paths.
- Reset (rst=1 at a rising edge):
  - out_valid, A_less_B, A_equal_B and A_greater_B all go to 0.
  - rst has priority over in_valid in the same cycle; that sample is discarded.
- Compare rule: unsigned by default; A and B are treated as plain WIDTH-bit values. Out-of-range stimulus is truncated by the driver to WIDTH bits before reaching the port, so 3+1 on 2 bits arrives as 0.
- Latency is 1 cycle. If in_valid=1 at edge N (rst=0), then after edge N:
  - out_valid=1;
  - exactly one of the three flags is 1, per the compare of the A/B values sampled at edge N.
- If in_valid=0 at an edge (rst=0):
  - out_valid=0;
  - the three flags hold their previous values (last result remains readable).
- Invariant: after the first accepted sample following reset, exactly one flag is high; before it, all flags are 0.
- Back-to-back samples are accepted every cycle; no backpressure and no ready signal.
- Inputs with X/Z are not supported; the bench must drive known values whenever in_valid=1.
- Combinational inputs-to-outputs paths are prohibited; all outputs come from flops.

Optional Feature:
- Macro: COMPARATOR_SIGNED_EN.
- Defined: A and B are compared as two's-complement signed WIDTH-bit values (2-bit: 2'b11 = -1 < 2'b00).
- Undefined: unsigned compare as above (2'b11 = 3 > 2'b00).
- Reset, latency, valid and hold rules are identical in both builds.

Decomposition:
- Package comparator_pkg:
  - constant index positions for the one-hot result (CMP_LT=0, CMP_EQ=1, CMP_GT=2);
  - a 3-bit result typedef cmp_result_t.
- Sub-module comparator_core: purely combinational; takes A and B, returns cmp_result_t. The signed/unsigned selection by COMPARATOR_SIGNED_EN lives only in comparator_core.
- comparator holds the input-valid register, result register and hold logic.

Test Plan:
- Reset: hold rst=1 with in_valid=1, A=1, B=2 -> out_valid=0 and all flags 0; they stay 0 after rst drops while in_valid=0.
- Less sweep, WIDTH=2, in_valid=1, one per cycle: (A,B) = (0,1), (1,2), (2,3) -> next cycle A_less_B=1 only, out_valid=1. Then (3,0) (wrapped 3+1) -> A_greater_B=1 unsigned; A_less_B=1 with COMPARATOR_SIGNED_EN.
- Equal sweep: (0,0), (1,1), (2,2), (3,3) -> A_equal_B=1 only, each one cycle after its sample.
- Greater sweep: (1,0), (2,1), (3,2), then (0,3) (wrapped 4) -> A_greater_B=1 for the first three; (0,3) gives A_less_B=1 unsigned, A_greater_B=1 signed.
- Hold: sample (2,1), then in_valid=0 for 3 cycles with A/B toggling randomly -> out_valid=0 and A_greater_B stays 1 throughout.
- Mid-stream reset: stream of 20 random samples, assert rst for one cycle at sample 10 -> flags and out_valid are 0 the cycle after, and correct results resume one cycle after the next accepted sample.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared definitions for the registered magnitude comparator.
// Index constants locate each flag inside the one-hot cmp_result_t.
package comparator_pkg;

    localparam int CMP_LT = 0;
    localparam int CMP_EQ = 1;
    localparam int CMP_GT = 2;

    typedef logic [2:0] cmp_result_t;

endpackage : comparator_pkg

// File: rtl/comparator_core.sv
// Combinational one-hot magnitude compare of two WIDTH-bit operands.
// Define COMPARATOR_SIGNED_EN to compare as two's-complement instead of unsigned.
module comparator_core
    import comparator_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_result_t      result
);

    logic is_less;
    logic is_equal;

    always_comb begin
        is_equal = (a == b);
`ifdef COMPARATOR_SIGNED_EN
        is_less  = ($signed(a) < $signed(b));
`else
        is_less  = (a < b);
`endif
    end

    // Greater is derived from the other two so exactly one flag is always set.
    always_comb begin
        result         = '0;
        result[CMP_LT] = is_less;
        result[CMP_EQ] = is_equal;
        result[CMP_GT] = !is_less && !is_equal;
    end

endmodule : comparator_core

// File: rtl/comparator.sv
// Registered comparator: one-cycle latency, flags hold when no new sample arrives.
// Signed compare is selected inside comparator_core by COMPARATOR_SIGNED_EN.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             A_less_B,
    output logic             A_equal_B,
    output logic             A_greater_B
);

    cmp_result_t cmp_next;
    cmp_result_t result_q;
    logic        valid_q;

    comparator_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (A),
        .b      (B),
        .result (cmp_next)
    );

    // Result only updates on an accepted sample, so the last compare stays readable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q <= cmp_next;
            end
        end
    end

    assign out_valid   = valid_q;
    assign A_less_B    = result_q[CMP_LT];
    assign A_equal_B   = result_q[CMP_EQ];
    assign A_greater_B = result_q[CMP_GT];

endmodule : comparator

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: table-driven sweeps plus reset/hold sequences.
// Expectations follow COMPARATOR_SIGNED_EN when the bench is built with it defined.
module tb_comparator;

    localparam int WIDTH = 2;

    // Flag encoding used throughout the bench: {greater, equal, less}.
    localparam logic [2:0] LT = 3'b001;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b100;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       exp_unsigned;
        logic [2:0]       exp_signed;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             A_less_B;
    logic             A_equal_B;
    logic             A_greater_B;

    logic [2:0] scoreboard[$];
    logic [2:0] model_flags;
    logic       exp_valid;
    int         n_vectors;
    int         n_miscompares;
    vec_t       vectors[15];

    comparator #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .A_less_B    (A_less_B),
        .A_equal_B   (A_equal_B),
        .A_greater_B (A_greater_B)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference compare built from integer arithmetic, independent of the RTL.
    function automatic logic [2:0] ref_compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int va;
        int vb;
        va = int'(a);
        vb = int'(b);
`ifdef COMPARATOR_SIGNED_EN
        if (a[WIDTH-1]) va = va - (1 << WIDTH);
        if (b[WIDTH-1]) vb = vb - (1 << WIDTH);
`endif
        if (va < vb) return LT;
        if (va == vb) return EQ;
        return GT;
    endfunction

    task automatic check_output(input string name);
        logic [2:0] got;
        n_vectors++;
        if (out_valid !== exp_valid) begin
            n_miscompares++;
            $display("[TB] FAIL %s out_valid: got %b expected %b", name, out_valid, exp_valid);
        end
        if (exp_valid && scoreboard.size() > 0) begin
            model_flags = scoreboard.pop_front();
        end
        got = {A_greater_B, A_equal_B, A_less_B};
        n_vectors++;
        if (got !== model_flags) begin
            n_miscompares++;
            $display("[TB] FAIL %s flags{gt,eq,lt}: got %b expected %b", name, got, model_flags);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic v, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic [2:0] exp, input string name);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        if (r) begin
            scoreboard.delete();
            model_flags = 3'b000;
            exp_valid   = 1'b0;
        end else if (v) begin
            scoreboard.push_back(exp);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_output(name);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [2:0]       exp;

        n_vectors     = 0;
        n_miscompares = 0;
        model_flags   = 3'b000;
        exp_valid     = 1'b0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        A             = '0;
        B             = '0;

        vectors[0]  = '{a: 2'd0, b: 2'd1, exp_unsigned: LT, exp_signed: LT};
        vectors[1]  = '{a: 2'd1, b: 2'd2, exp_unsigned: LT, exp_signed: GT};
        vectors[2]  = '{a: 2'd2, b: 2'd3, exp_unsigned: LT, exp_signed: LT};
        vectors[3]  = '{a: 2'd3, b: 2'd0, exp_unsigned: GT, exp_signed: LT};
        vectors[4]  = '{a: 2'd0, b: 2'd0, exp_unsigned: EQ, exp_signed: EQ};
        vectors[5]  = '{a: 2'd1, b: 2'd1, exp_unsigned: EQ, exp_signed: EQ};
        vectors[6]  = '{a: 2'd2, b: 2'd2, exp_unsigned: EQ, exp_signed: EQ};
        vectors[7]  = '{a: 2'd3, b: 2'd3, exp_unsigned: EQ, exp_signed: EQ};
        vectors[8]  = '{a: 2'd1, b: 2'd0, exp_unsigned: GT, exp_signed: GT};
        vectors[9]  = '{a: 2'd2, b: 2'd1, exp_unsigned: GT, exp_signed: LT};
        vectors[10] = '{a: 2'd3, b: 2'd2, exp_unsigned: GT, exp_signed: GT};
        vectors[11] = '{a: 2'd0, b: 2'd3, exp_unsigned: LT, exp_signed: GT};
        vectors[12] = '{a: 2'd3, b: 2'd1, exp_unsigned: GT, exp_signed: LT};
        vectors[13] = '{a: 2'd0, b: 2'd2, exp_unsigned: LT, exp_signed: GT};
        vectors[14] = '{a: 2'd1, b: 2'd3, exp_unsigned: LT, exp_signed: GT};

        // Reset wins over a valid sample; outputs stay clear once reset drops.
        apply_stimulus(1'b1, 1'b1, 2'd1, 2'd2, LT, "reset_with_valid");
        apply_stimulus(1'b1, 1'b1, 2'd1, 2'd2, LT, "reset_held");
        apply_stimulus(1'b0, 1'b0, 2'd1, 2'd2, LT, "post_reset_idle0");
        apply_stimulus(1'b0, 1'b0, 2'd3, 2'd0, GT, "post_reset_idle1");

        // Back-to-back table sweep.
        for (int i = 0; i < 15; i++) begin
`ifdef COMPARATOR_SIGNED_EN
            exp = vectors[i].exp_signed;
`else
            exp = vectors[i].exp_unsigned;
`endif
            apply_stimulus(1'b0, 1'b1, vectors[i].a, vectors[i].b, exp, $sformatf("table[%0d]", i));
        end

        // Hold: last result must persist while inputs wiggle without in_valid.
        apply_stimulus(1'b0, 1'b1, 2'd2, 2'd1, ref_compare(2'd2, 2'd1), "hold_sample");
        for (int i = 0; i < 3; i++) begin
            ra = WIDTH'($urandom_range(0, 3));
            rb = WIDTH'($urandom_range(0, 3));
            apply_stimulus(1'b0, 1'b0, ra, rb, ref_compare(ra, rb), $sformatf("hold[%0d]", i));
        end

        // Random stream with a one-cycle reset landing on sample 10.
        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom_range(0, 3));
            rb = WIDTH'($urandom_range(0, 3));
            apply_stimulus((i == 10), 1'b1, ra, rb, ref_compare(ra, rb), $sformatf("stream[%0d]", i));
        end

        // Mixed valid/idle random traffic exercises hold between accepted samples.
        for (int i = 0; i < 16; i++) begin
            ra = WIDTH'($urandom_range(0, 3));
            rb = WIDTH'($urandom_range(0, 3));
            apply_stimulus(1'b0, 1'($urandom_range(0, 1)), ra, rb, ref_compare(ra, rb), $sformatf("mixed[%0d]", i));
        end

        in_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_comparator
